// File: rtl/keys_input_pio.sv
// keys_input_pio: Avalon-MM push-button input port with synchroniser, debouncer, edge capture and IRQ.
// Define KEYS_DEBOUNCE_EN to build the tick-gated debouncer; otherwise deb follows sync2 every cycle.
module keys_input_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          RESET_LEVEL     = 1'b1,
    parameter bit          CAPTURE_RISING  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE      = {WIDTH{RESET_LEVEL}};
    localparam logic [1:0]       ADDR_DATA = 2'd0;
    localparam logic [1:0]       ADDR_MASK = 2'd2;
    localparam logic [1:0]       ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d, deb_prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_w, clr_w;
    logic             wr_en;
    logic             tick;
    logic             unused_wdata;

    assign unused_wdata = ^(writedata >> WIDTH);

`ifdef KEYS_DEBOUNCE_EN
    localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign tick = 1'b1;
`endif

    always_comb begin
        wr_en  = chipselect & ~write_n;
        edge_w = CAPTURE_RISING ? (deb_q & ~deb_prev_q) : (~deb_q & deb_prev_q);
        clr_w  = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        // Edge is OR-ed after the clear so a simultaneous edge keeps the bit set.
        cap_d  = (cap_q & ~clr_w) | edge_w;
        mask_d = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        deb_d  = tick ? sync2_q : deb_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= IDLE;
            sync2_q    <= IDLE;
            deb_q      <= IDLE;
            deb_prev_q <= IDLE;
            mask_q     <= '0;
            cap_q      <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = deb_q;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_keys_input_pio.sv
// Self-checking bench for keys_input_pio: reset/register table, directed corner sequences and
// randomized traffic against a cycle-indexed reference model of the input pipeline and registers.
module tb_keys_input_pio;

    localparam int unsigned W  = 4;
    localparam int unsigned DC = 4;
    localparam bit          RL = 1'b1;
    localparam bit          CR = 1'b0;
`ifdef KEYS_DEBOUNCE_EN
    localparam int unsigned P = DC;
`else
    localparam int unsigned P = 1;
`endif
    localparam logic [W-1:0] IDLE = {W{RL}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    keys_input_pio #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL(RL),
        .CAPTURE_RISING(CR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: inputs sampled at each edge are kept in a history queue; the debounced
    // value at a tick edge k is whatever was sampled at edge k-2. k counts edges since reset release.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_deb, m_prev, m_cap, m_mask;
    int unsigned  m_k;

    task automatic m_reset();
        m_hist.delete();
        m_hist.push_back(IDLE);
        m_hist.push_back(IDLE);
        m_deb  = IDLE;
        m_prev = IDLE;
        m_cap  = '0;
        m_mask = '0;
        m_k    = 0;
    endtask

    function automatic logic [W-1:0] m_edges();
        return CR ? (m_deb & ~m_prev) : (~m_deb & m_prev);
    endfunction

    task automatic m_edge();
        logic [W-1:0] ev, clr, nmask, ndeb;
        bit wr;
        if (!reset_n) return;
        wr    = chipselect && !write_n;
        ev    = m_edges();
        clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        nmask = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
        ndeb  = ((m_k % P) == P - 1) ? m_hist[0] : m_deb;
        m_prev = m_deb;
        m_deb  = ndeb;
        m_cap  = (m_cap & ~clr) | ev;
        m_mask = nmask;
        void'(m_hist.pop_front());
        m_hist.push_back(in_port);
        m_k++;
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        #1;
        check("model_rd", readdata, m_rd(address));
        check("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(nm, readdata, exp);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen, hit;
        int n;

        tbl[0] = '{2'd0, 1'b0, 32'h0,        32'h0000000F, 1'b0};
        tbl[1] = '{2'd1, 1'b0, 32'h0,        32'h00000000, 1'b0};
        tbl[2] = '{2'd2, 1'b0, 32'h0,        32'h00000000, 1'b0};
        tbl[3] = '{2'd3, 1'b0, 32'h0,        32'h00000000, 1'b0};
        tbl[4] = '{2'd2, 1'b1, 32'hFFFFFFF5, 32'h00000005, 1'b0};
        tbl[5] = '{2'd0, 1'b1, 32'hFFFFFFFF, 32'h0000000F, 1'b0};
        tbl[6] = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[7] = '{2'd3, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[8] = '{2'd2, 1'b1, 32'h00000000, 32'h00000000, 1'b0};

        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        m_reset();
        @(negedge clk);
        steps(3);
        reset_n = 1'b1;

        // Reset state, register map, ignored writes
        for (int i = 0; i < 9; i++) begin
            address    = tbl[i].addr;
            chipselect = tbl[i].wr;
            write_n    = !tbl[i].wr;
            writedata  = tbl[i].wdata;
            step();
            address = tbl[i].addr;
            #1;
            check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end

        // Falling edge on bit 0: latency, capture, masked irq
        in_port = 4'hE;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 2 + P + 3 && !seen; i++) begin
            address = 2'd0;
            step();
            n = i + 1;
            seen = (readdata == 32'h0000000E);
        end
        checks++;
        if (!seen || n > 2 + P) begin
            errors++;
            $display("FAIL data_latency: got %0d cycles (seen=%0d) required <= %0d", n, seen, 2 + P);
        end
        step();
        rd_chk("cap_bit0", 2'd3, 32'h1);
        check("irq_masked", 32'(irq), 32'd0);
        bus_wr(2'd2, 32'h1);
        check("irq_unmasked", 32'(irq), 32'd1);

        // One-cycle glitch on bit 1, placed away from the sampling tick
        in_port = 4'hF;
        steps(P + 4);
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd2, 32'h0);
        for (int i = 0; i < P + 1 && ((m_k + 2) % P) != 0; i++) step();
        in_port = 4'hD;
        step();
        in_port = 4'hF;
        steps(P + 4);
        rd_chk("glitch_data", 2'd0, 32'hF);
`ifdef KEYS_DEBOUNCE_EN
        rd_chk("glitch_cap", 2'd3, 32'h0);
`else
        rd_chk("glitch_cap", 2'd3, 32'h2);
`endif

        // Write-1-to-clear with mask fully open
        bus_wr(2'd3, 32'hF);
        in_port = 4'hC;
        steps(P + 4);
        rd_chk("cap_two", 2'd3, 32'h3);
        bus_wr(2'd2, 32'hF);
        check("irq_two", 32'(irq), 32'd1);
        bus_wr(2'd3, 32'h1);
        rd_chk("clr_bit0", 2'd3, 32'h2);
        check("irq_after_clr0", 32'(irq), 32'd1);
        bus_wr(2'd3, 32'h2);
        rd_chk("clr_bit1", 2'd3, 32'h0);
        check("irq_after_clr1", 32'(irq), 32'd0);

        // Edge and clear on bit 2 in the same cycle
        in_port = 4'h8;
        hit = 1'b0;
        for (int i = 0; i < 2 * P + 8 && !hit; i++) begin
            if (m_edges()[2]) begin
                bus_wr(2'd3, 32'h4);
                hit = 1'b1;
            end else begin
                address = 2'd3;
                step();
            end
        end
        check("edge_wins_timed", 32'(hit), 32'd1);
        rd_chk("edge_wins_cap", 2'd3, 32'h4);
        check("edge_wins_irq", 32'(irq), 32'd1);

        // Asynchronous reset mid-capture
        reset_n = 1'b0;
        m_reset();
        #1;
        check("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_data", 2'd0, 32'hF);
        rd_chk("rst_res", 2'd1, 32'h0);
        rd_chk("rst_mask", 2'd2, 32'h0);
        rd_chk("rst_cap", 2'd3, 32'h0);
        steps(2);
        in_port = 4'hF;
        reset_n = 1'b1;
        address = 2'd3;
        steps(P + 4);
        rd_chk("rst_release_cap", 2'd3, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
